// File: rtl/tictactoe_board.sv
// TicTacToe board store: validates placements, scans the eight lines one per cycle, reports win/tie.
// Optional per-player score counters are enabled with `define TTT_BOARD_SCORE_EN.
module tictactoe_board #(
   parameter int unsigned SCORE_W = 4
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               clear,
   input  logic               place_valid,
   input  logic [3:0]         place_cell,
   input  logic               place_player,
   output logic               place_ack,
   output logic               place_reject,
   output logic               busy,
   output logic [8:0]         board_x,
   output logic [8:0]         board_o,
   output logic               win_x,
   output logic               win_o,
   output logic               tie,
   output logic [2:0]         win_line
`ifdef TTT_BOARD_SCORE_EN
   ,
   output logic [SCORE_W-1:0] score_x,
   output logic [SCORE_W-1:0] score_o
`endif
);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   state_t      state, state_next;
   logic [2:0]  line_idx;
   logic        mover;
   logic        hit;
   logic [2:0]  hit_line;

   logic [8:0]  cell_mask;
   logic [8:0]  mover_board;
   logic [8:0]  cur_mask;
   logic        legal, accept, refuse;
   logic        line_match, scan_done, win_now, board_full;
   logic [2:0]  final_line;

   function automatic logic [8:0] line_mask(input logic [2:0] idx);
      case (idx)
         3'd0:    line_mask = 9'b000_000_111;
         3'd1:    line_mask = 9'b000_111_000;
         3'd2:    line_mask = 9'b111_000_000;
         3'd3:    line_mask = 9'b001_001_001;
         3'd4:    line_mask = 9'b010_010_010;
         3'd5:    line_mask = 9'b100_100_100;
         3'd6:    line_mask = 9'b100_010_001;
         default: line_mask = 9'b001_010_100;
      endcase
   endfunction

   always_comb begin
      // Cells 9..15 shift the single bit out of the 9-bit mask, so they never look occupied.
      cell_mask   = 9'd1 << place_cell;
      board_full  = &(board_x | board_o);
      legal       = (place_cell <= 4'd8) && (((board_x | board_o) & cell_mask) == '0);
      accept      = !clear && place_valid && (state == IDLE) && legal;
      refuse      = !clear && place_valid && !accept;
      mover_board = mover ? board_o : board_x;
      cur_mask    = line_mask(line_idx);
      line_match  = (mover_board & cur_mask) == cur_mask;
      scan_done   = (state == CHECK) && (line_idx == 3'd7);
      win_now     = scan_done && (hit || line_match);
      final_line  = hit ? hit_line : line_idx;
      busy        = (state == CHECK);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CHECK;
         CHECK:   if (line_idx == 3'd7) state_next = (win_now || board_full) ? OVER : IDLE;
         OVER:    state_next = OVER;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         board_x      <= '0;
         board_o      <= '0;
         win_x        <= 1'b0;
         win_o        <= 1'b0;
         tie          <= 1'b0;
         win_line     <= '0;
         place_ack    <= 1'b0;
         place_reject <= 1'b0;
         line_idx     <= '0;
         mover        <= 1'b0;
         hit          <= 1'b0;
         hit_line     <= '0;
`ifdef TTT_BOARD_SCORE_EN
         score_x      <= '0;
         score_o      <= '0;
`endif
      end else if (clear) begin
         board_x      <= '0;
         board_o      <= '0;
         win_x        <= 1'b0;
         win_o        <= 1'b0;
         tie          <= 1'b0;
         win_line     <= '0;
         place_ack    <= 1'b0;
         place_reject <= 1'b0;
         line_idx     <= '0;
         mover        <= 1'b0;
         hit          <= 1'b0;
         hit_line     <= '0;
      end else begin
         place_ack    <= accept;
         place_reject <= refuse;
         if (accept) begin
            if (place_player) board_o <= board_o | cell_mask;
            else              board_x <= board_x | cell_mask;
            mover    <= place_player;
            line_idx <= '0;
            hit      <= 1'b0;
         end
         if (state == CHECK) begin
            // Keep only the first matching line so a double win reports the lower index.
            if (line_match && !hit) begin
               hit      <= 1'b1;
               hit_line <= line_idx;
            end
            line_idx <= line_idx + 3'd1;
         end
         if (win_now) begin
            win_line <= final_line;
            if (mover) begin
               win_o <= 1'b1;
`ifdef TTT_BOARD_SCORE_EN
               if (score_o != '1) score_o <= score_o + SCORE_W'(1);
`endif
            end else begin
               win_x <= 1'b1;
`ifdef TTT_BOARD_SCORE_EN
               if (score_x != '1) score_x <= score_x + SCORE_W'(1);
`endif
            end
         end else if (scan_done && board_full) begin
            tie <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tictactoe_board.sv
// Scoreboard bench for tictactoe_board: a move-level game model queues expected pulses and results.
// Score checks are compiled in when TTT_BOARD_SCORE_EN is defined.
module tb_tictactoe_board;

   localparam int unsigned SW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic          place_valid = 1'b0;
   logic [3:0]    place_cell = '0;
   logic          place_player = 1'b0;
   logic          place_ack, place_reject, busy;
   logic [8:0]    board_x, board_o;
   logic          win_x, win_o, tie;
   logic [2:0]    win_line;
`ifdef TTT_BOARD_SCORE_EN
   logic [SW-1:0] score_x, score_o;
`endif

   tictactoe_board #(.SCORE_W(SW)) dut (
      .clk_100MHz   (clk),
      .reset        (reset),
      .clear        (clear),
      .place_valid  (place_valid),
      .place_cell   (place_cell),
      .place_player (place_player),
      .place_ack    (place_ack),
      .place_reject (place_reject),
      .busy         (busy),
      .board_x      (board_x),
      .board_o      (board_o),
      .win_x        (win_x),
      .win_o        (win_o),
      .tie          (tie),
      .win_line     (win_line)
`ifdef TTT_BOARD_SCORE_EN
      ,
      .score_x      (score_x),
      .score_o      (score_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       ack;
      bit [8:0] bx;
      bit [8:0] bo;
   } resp_t;

   typedef struct {
      bit       wx;
      bit       wo;
      bit       t;
      bit [2:0] wl;
      bit [8:0] bx;
      bit [8:0] bo;
      int       len;
      int       sx;
      int       so;
   } res_t;

   resp_t rq[$];
   res_t  resq[$];

   int vectors = 0;
   int miscompares = 0;

   // Game model state
   bit [8:0] mx, mo;
   bit       m_wx, m_wo, m_tie, over;
   bit [2:0] m_wl;
   int       busy_left = 0;
   int       sx = 0, so = 0, sx_saved = 0, so_saved = 0;
   int       lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int       smax = (1 << SW) - 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear_board();
      mx = '0; mo = '0;
      m_wx = 0; m_wo = 0; m_tie = 0; m_wl = '0; over = 0;
   endtask

   task automatic model_edge(input bit v, input logic [3:0] c, input bit p, input bit clr);
      resp_t r;
      res_t  s;
      bit [8:0] mine;
      bit found, was_busy;
      int ci;
      if (clr) begin
         if (busy_left > 0) begin
            // Scan aborted: the pending result becomes an empty board after a shortened busy.
            void'(resq.pop_back());
            s = '{default: 0};
            s.len = 9 - busy_left;
            s.sx = sx_saved; s.so = so_saved;
            sx = sx_saved; so = so_saved;
            resq.push_back(s);
         end
         model_clear_board();
         busy_left = 0;
         return;
      end
      was_busy = (busy_left > 0);
      if (was_busy) busy_left--;
      if (!v) return;
      ci = int'(c);
      if (!was_busy && !over && ci <= 8 && !mx[ci] && !mo[ci]) begin
         if (p) mo[ci] = 1'b1; else mx[ci] = 1'b1;
         r.ack = 1; r.bx = mx; r.bo = mo;
         rq.push_back(r);
         sx_saved = sx; so_saved = so;
         mine = p ? mo : mx;
         found = 0;
         for (int l = 0; l < 8; l++)
            if (!found && mine[lines[l][0]] && mine[lines[l][1]] && mine[lines[l][2]]) begin
               found = 1;
               m_wl = 3'(l);
            end
         if (found) begin
            over = 1;
            if (p) begin m_wo = 1; if (so < smax) so++; end
            else   begin m_wx = 1; if (sx < smax) sx++; end
         end else if (&(mx | mo)) begin
            over = 1;
            m_tie = 1;
         end
         s.wx = m_wx; s.wo = m_wo; s.t = m_tie; s.wl = found ? m_wl : 3'd0;
         s.bx = mx; s.bo = mo; s.len = 8; s.sx = sx; s.so = so;
         resq.push_back(s);
         busy_left = 8;
      end else begin
         r.ack = 0; r.bx = mx; r.bo = mo;
         rq.push_back(r);
      end
   endtask

   task automatic step(input bit v, input logic [3:0] c, input bit p, input bit clr);
      @(negedge clk);
      place_valid = v; place_cell = c; place_player = p; clear = clr;
      model_edge(v, c, p, clr);
      @(posedge clk);
   endtask

   task automatic mv(input int c, input bit p);
      step(1'b1, 4'(c), p, 1'b0);
      repeat (8) step(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; place_valid = 1'b0; clear = 1'b0;
      model_clear_board();
      busy_left = 0; sx = 0; so = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack", place_ack, 0);
      chk("rst_reject", place_reject, 0);
      chk("rst_busy", busy, 0);
      chk("rst_board_x", board_x, 0);
      chk("rst_board_o", board_o, 0);
      chk("rst_flags", {win_x, win_o, tie}, 0);
      chk("rst_win_line", win_line, 0);
`ifdef TTT_BOARD_SCORE_EN
      chk("rst_score_x", score_x, 0);
      chk("rst_score_o", score_o, 0);
`endif
      reset = 1'b0;
   endtask

   // Monitor: pops on every ack/reject pulse and on every falling edge of busy.
   bit prev_busy = 0;
   int blen = 0;
   always @(negedge clk) begin
      resp_t r;
      res_t  s;
      if (reset) begin
         prev_busy = 0;
         blen = 0;
      end else begin
         if (place_ack || place_reject) begin
            if (rq.size() == 0) chk("unexpected_pulse", {place_ack, place_reject}, 0);
            else begin
               r = rq.pop_front();
               chk("ack", place_ack, r.ack);
               chk("reject", place_reject, !r.ack);
               chk("pulse_board_x", board_x, r.bx);
               chk("pulse_board_o", board_o, r.bo);
            end
         end
         if (busy) blen++;
         else if (prev_busy) begin
            if (resq.size() == 0) chk("spurious_busy_fall", prev_busy, 0);
            else begin
               s = resq.pop_front();
               chk("busy_len", blen, s.len);
               chk("win_x", win_x, s.wx);
               chk("win_o", win_o, s.wo);
               chk("tie", tie, s.t);
               chk("win_line", win_line, s.wl);
               chk("res_board_x", board_x, s.bx);
               chk("res_board_o", board_o, s.bo);
`ifdef TTT_BOARD_SCORE_EN
               chk("score_x", score_x, s.sx);
               chk("score_o", score_o, s.so);
`endif
            end
            blen = 0;
         end
         prev_busy = busy;
      end
   end

   initial begin
      do_reset();

      // Row win, then a move after game over
      step(0, 0, 0, 1);
      mv(0, 0); mv(3, 1); mv(1, 0); mv(4, 1); mv(2, 0);
      mv(5, 1);

      // Illegal moves
      step(0, 0, 0, 1);
      mv(4, 0); mv(4, 1); mv(9, 0);

      // Tie
      step(0, 0, 0, 1);
      mv(0, 0); mv(1, 1); mv(2, 0); mv(3, 0); mv(4, 1);
      mv(5, 0); mv(6, 1); mv(7, 0); mv(8, 1);

      // O completes the anti-diagonal only
      step(0, 0, 0, 1);
      mv(0, 0); mv(2, 1); mv(1, 0); mv(4, 1); mv(5, 0); mv(6, 1);

      // X completes row 0 and diagonal 6 together
      step(0, 0, 0, 1);
      mv(1, 0); mv(3, 1); mv(2, 0); mv(5, 1); mv(4, 0); mv(7, 1); mv(8, 0); mv(0, 0);

      // Requests held during busy, then clear at CHECK cycle 3 alongside a request
      step(0, 0, 0, 1);
      step(1, 4'd4, 0, 0);
      repeat (8) step(1, 4'd0, 1, 0);
      step(1, 4'd8, 1, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(1, 4'd2, 0, 1);
      repeat (3) step(0, 0, 0, 0);

      // Randomized games
      for (int g = 0; g < 30; g++) begin
         step(0, 0, 0, 1);
         for (int i = 0; i < 80; i++) begin
            automatic bit         v   = ($urandom_range(0, 3) != 0);
            automatic logic [3:0] c   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                                   : 4'($urandom_range(0, 8));
            automatic bit         p   = 1'($urandom_range(0, 1));
            automatic bit         clr = ($urandom_range(0, 99) == 0);
            step(v, c, p, clr);
         end
      end

`ifdef TTT_BOARD_SCORE_EN
      do_reset();
      for (int g = 0; g < 16; g++) begin
         step(0, 0, 0, 1);
         mv(0, 0); mv(3, 1); mv(1, 0); mv(4, 1); mv(2, 0);
      end
      @(negedge clk);
      chk("score_x_sat", score_x, 15);
      chk("score_o_zero", score_o, 0);
      do_reset();
`endif

      repeat (12) step(0, 0, 0, 0);
      chk("pending_pulses", rq.size(), 0);
      chk("pending_results", resq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tictactoe_board.md
# tictactoe_board

Game-board store and result detector for the TicTacToe design. Sits downstream of the `FinitStateMachine` move outputs and upstream of the VGA painter and the screen-select logic. It accepts one placement request at a time, rejects illegal moves, and scans the eight winning lines sequentially. It then reports win, tie or continue, and exposes the 3×3 occupancy maps for drawing.

## Interface
Parameters:
- `SCORE_W`, default 4: width of the optional score counters.

Ports:
- `clk_100MHz` in 1: system clock. One clock domain; all logic on the rising edge.
- `reset` in 1: synchronous, active-high. Clears everything, including the scores.
- `clear` in 1: synchronous new-game request. Clears the board, flags and FSM. Scores are kept.
- `place_valid` in 1: placement request, sampled every cycle.
- `place_cell` in 4: target cell, equal to row*3+col. Legal values are 0..8.
- `place_player` in 1: 0 means X, 1 means O.
- `place_ack` out 1: one-cycle pulse when a move is accepted.
- `place_reject` out 1: one-cycle pulse when a move is refused.
- `busy` out 1: high while the line scan is in progress.
- `board_x` out 9: bit i is set when cell i holds X.
- `board_o` out 9: bit i is set when cell i holds O.
- `win_x` out 1: level output. X has won. Held until `clear` or `reset`.
- `win_o` out 1: level output. O has won. Held until `clear` or `reset`.
- `tie` out 1: level output. The board is full with no win. Held until `clear` or `reset`.
- `win_line` out 3: index of the winning line. Valid only while `win_x` or `win_o` is high; otherwise 0.
- `score_x`, `score_o` out SCORE_W: present only with `TTT_BOARD_SCORE_EN`.

## Operation
- States:
  - IDLE: accepts moves.
  - CHECK: scans lines, one per cycle.
  - OVER: game finished; all moves are rejected.
- Line index order:
  - Rows: 0 = {0,1,2}, 1 = {3,4,5}, 2 = {6,7,8}.
  - Columns: 3 = {0,3,6}, 4 = {1,4,7}, 5 = {2,5,8}.
  - Diagonals: 6 = {0,4,8}, 7 = {2,4,6}.
- A move is accepted only when all of the following hold:
  - the state is IDLE,
  - `place_valid` = 1,
  - `place_cell` ≤ 8,
  - the target cell is empty in both `board_x` and `board_o`.
- On acceptance:
  - set the bit for `place_player`,
  - latch the mover,
  - enter CHECK with the line counter at 0.
- Reject conditions: `place_valid` = 1 together with any of:
  - cell > 8,
  - the target cell is occupied,
  - the state is CHECK or OVER.
- On rejection: the board is unchanged. The mover's turn is the FSM's responsibility.
- CHECK, per cycle:
  - If all three cells of the current line belong to the latched mover, record `win_line` = the line index.
  - Only the first matching line in scan order is recorded; a double win reports the lower index.
- End of scan, after the cycle that tests line 7:
  - If a match was found: the win flag of the mover goes high, then OVER.
  - Else, if the board is full (`board_x` | `board_o` = 9'h1FF): `tie` goes high, then OVER.
  - Else: IDLE.
- Priority: `reset` > `clear` > placement. When `clear` and `place_valid` are both high, `clear` wins; neither ack nor reject pulses.
- `clear` mid-CHECK aborts the scan. The next cycle is IDLE with an empty board.

## Timing
- Reset values: every output is 0, the state is IDLE, and the scores are 0.
- For a request sampled at edge N:
  - `place_ack` or `place_reject` is high during cycle N+1 only.
  - On acceptance, `board_x`/`board_o` show the new bit from N+1.
- `busy` is high for exactly 8 cycles, N+1..N+8, with line k tested in cycle N+1+k.
- Result flags are high from cycle N+9. `busy` is 0 from N+9, and a new move can be accepted at edge N+9.
- Holding `place_valid` high during `busy` produces one reject pulse per cycle.
- The maximum move rate is one accepted move per 9 cycles.

## Configuration
- `TTT_BOARD_SCORE_EN`, when defined:
  - adds `score_x` and `score_o`,
  - increments the winner's score in the same cycle its win flag rises,
  - saturates at 2^SCORE_W−1,
  - a tie does not change either score,
  - only `reset` clears the scores.
- Undefined: the score ports and counters are absent. All other behaviour is identical.

## Test plan
- Row win:
  - Stimulus: X@0, O@3, X@1, O@4, X@2, each issued after `busy` falls.
  - Response: `win_x` = 1 and `win_line` = 0 exactly 9 cycles after the X@2 request edge; `board_x` = 9'h007; then O@5 gets `place_reject`.
- Illegal moves:
  - Stimulus: X@4, then O@4, then X with cell 9.
  - Response: both later requests pulse `place_reject` for one cycle; `board_o` = 0; `board_x` = 9'h010.
- Tie:
  - Stimulus: X0 O1 X2 X3 O4 X5 O6 X7 O8.
  - Response: `tie` = 1, `win_x` = `win_o` = 0, board fully occupied.
- Diagonal / double-line win:
  - Stimulus: a game ending with O completing line 7 only.
  - Response: `win_o` = 1, `win_line` = 7.
  - Stimulus: a game where X's final move completes lines 0 and 6.
  - Response: `win_line` = 0.
- Busy and clear:
  - Stimulus: `place_valid` during `busy` cycles 1..8.
  - Response: one reject pulse per cycle.
  - Stimulus: `clear` asserted at CHECK cycle 3 together with `place_valid`.
  - Response: next cycle board = 0, IDLE, no ack or reject.
- Scores (with `TTT_BOARD_SCORE_EN`):
  - Stimulus: 16 X wins separated by `clear`.
  - Response: `score_x` = 15 (saturated), `score_o` = 0.
  - Stimulus: `reset`.
  - Response: both scores 0.
